y86_mc_ctrl: RTL and testbench

- Multi-cycle sequencer for the Y86-64 datapath; the next generation after the single-cycle core.
- Runs each instruction through FETCH/DECODE/EXEC/MEM/WB/PC states and emits per-state write enables.
- Uses req/ack handshakes to variable-latency instruction and data memories, with optional timeout.
- Owns architectural status and performance counters. The existing datapath blocks (regs, ALU, CC, mem) remain combinational consumers of its enables.

---
 rtl/y86_mc_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_y86_mc_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/y86_mc_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// y86_mc_ctrl : multi-cycle Y86-64 sequencer with req/ack memories and counters
// Rev 1.0
// ---------------------------------------------------------------------------
module y86_mc_ctrl #(
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 16,
   parameter int WAIT_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       icode,
   input  logic             instr_valid,
   input  logic             imem_ack,
   input  logic             imem_error,
   input  logic             dmem_ack,
   input  logic             dmem_error,
   output logic             imem_req,
   output logic             dmem_req,
   output logic             dmem_wr,
   output logic             ir_we,
   output logic             cc_we,
   output logic             val_we,
   output logic             reg_we,
   output logic             pc_we,
   output logic [2:0]       stat,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instr_cnt
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_PC     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   localparam logic [2:0]        STAT_AOK = 3'd1;
   localparam logic [2:0]        STAT_HLT = 3'd2;
   localparam logic [2:0]        STAT_ADR = 3'd3;
   localparam logic [2:0]        STAT_INS = 3'd4;
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
   localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

   state_t            state_q, state_d;
   logic [2:0]        stat_q, stat_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
   logic [CNT_W-1:0]  instr_cnt_q, instr_cnt_d;
   logic              halted_q, halted_d;

   logic imem_req_c, dmem_req_c, dmem_wr_c, ir_we_c;
   logic cc_we_c, val_we_c, reg_we_c, pc_we_c;
   logic timeout_hit;
   logic [WAIT_W-1:0] wait_inc;

   // Timeout fires in the cycle whose unacked wait would reach the limit.
   assign timeout_hit = (MEM_TIMEOUT > 0) && (int'(wait_q) == MEM_TIMEOUT - 1);
   assign wait_inc    = (wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1;

   always_comb begin
      state_d    = state_q;
      stat_d     = stat_q;
      wait_d     = '0;
      imem_req_c = 1'b0;
      dmem_req_c = 1'b0;
      dmem_wr_c  = 1'b0;
      ir_we_c    = 1'b0;
      cc_we_c    = 1'b0;
      val_we_c   = 1'b0;
      reg_we_c   = 1'b0;
      pc_we_c    = 1'b0;
      case (state_q)
         S_FETCH: begin
            imem_req_c = 1'b1;
            if (imem_ack) begin
               if (imem_error) begin
                  stat_d  = STAT_ADR;
                  state_d = S_HALT;
               end else begin
                  ir_we_c = 1'b1;
                  state_d = S_DECODE;
               end
            end else if (timeout_hit) begin
               stat_d  = STAT_ADR;
               state_d = S_HALT;
            end else begin
               wait_d = wait_inc;
            end
         end
         S_DECODE: begin
            if (!instr_valid) begin
               stat_d  = STAT_INS;
               state_d = S_HALT;
            end else if (icode == 4'h0) begin
               stat_d  = STAT_HLT;
               state_d = S_HALT;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            val_we_c = 1'b1;
            cc_we_c  = (icode == 4'h6);
            case (icode)
               4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: state_d = S_MEM;
               4'h2, 4'h3, 4'h6:                   state_d = S_WB;
               default:                            state_d = S_PC;
            endcase
         end
         S_MEM: begin
            dmem_req_c = 1'b1;
            dmem_wr_c  = (icode == 4'h4) || (icode == 4'h8) || (icode == 4'hA);
            if (dmem_ack) begin
               if (dmem_error) begin
                  stat_d  = STAT_ADR;
                  state_d = S_HALT;
               end else begin
                  state_d = S_WB;
               end
            end else if (timeout_hit) begin
               stat_d  = STAT_ADR;
               state_d = S_HALT;
            end else begin
               wait_d = wait_inc;
            end
         end
         S_WB: begin
            case (icode)
               4'h2, 4'h3, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB: reg_we_c = 1'b1;
               default:                                        reg_we_c = 1'b0;
            endcase
            state_d = S_PC;
         end
         S_PC: begin
            pc_we_c = 1'b1;
            state_d = S_FETCH;
         end
         S_HALT: state_d = S_HALT;
         default: begin
            stat_d  = STAT_INS;
            state_d = S_HALT;
         end
      endcase
   end

   // The first HALT cycle still counts as the cycle of the transition.
   always_comb begin
      halted_d    = (state_q == S_HALT);
      cycle_cnt_d = cycle_cnt_q;
      instr_cnt_d = instr_cnt_q;
      if (!(halted_d && halted_q) && (cycle_cnt_q != CNT_MAX))
         cycle_cnt_d = cycle_cnt_q + 1'b1;
      if ((state_q == S_PC) && (instr_cnt_q != CNT_MAX))
         instr_cnt_d = instr_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_FETCH;
         stat_q      <= STAT_AOK;
         wait_q      <= '0;
         cycle_cnt_q <= '0;
         instr_cnt_q <= '0;
         halted_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         stat_q      <= stat_d;
         wait_q      <= wait_d;
         cycle_cnt_q <= cycle_cnt_d;
         instr_cnt_q <= instr_cnt_d;
         halted_q    <= halted_d;
      end
   end

   assign imem_req  = imem_req_c & ~rst;
   assign dmem_req  = dmem_req_c & ~rst;
   assign dmem_wr   = dmem_wr_c  & ~rst;
   assign ir_we     = ir_we_c    & ~rst;
   assign cc_we     = cc_we_c    & ~rst;
   assign val_we    = val_we_c   & ~rst;
   assign reg_we    = reg_we_c   & ~rst;
   assign pc_we     = pc_we_c    & ~rst;
   assign stat      = stat_q;
   assign state     = state_q;
   assign cycle_cnt = cycle_cnt_q;
   assign instr_cnt = instr_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_y86_mc_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_y86_mc_ctrl : directed self-checking bench for the multi-cycle sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_y86_mc_ctrl;

   logic        clk   = 1'b0;
   logic        rst   = 1'b0;
   logic        rst_b = 1'b0;
   logic [3:0]  icode;
   logic        instr_valid;
   logic        imem_ack, imem_error, dmem_ack, dmem_error;
   logic        imem_req, dmem_req, dmem_wr, ir_we, cc_we, val_we, reg_we, pc_we;
   logic [2:0]  stat, state;
   logic [31:0] cycle_cnt, instr_cnt;

   logic        imem_req_b, dmem_req_b, dmem_wr_b, ir_we_b, cc_we_b, val_we_b, reg_we_b, pc_we_b;
   logic [2:0]  stat_b, state_b;
   logic [7:0]  cycle_cnt_b, instr_cnt_b;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   imem_lat = 0;
   int   dmem_lat = 0;
   logic imem_err_en = 1'b0;
   logic dmem_err_en = 1'b0;
   int   i_wait, d_wait;
   logic [3:0] prog   [0:7];
   logic       pvalid [0:7];
   logic [2:0] pc;

   logic [2:0] tr_state [0:31];
   logic       tr_ccwe  [0:31];
   logic       tr_irwe  [0:31];
   logic       tr_dwr   [0:31];
   int c_imreq, c_irwe, c_ccwe, c_dreq, c_dwr, c_regwe, c_pcwe;

   always #5 clk = ~clk;

   y86_mc_ctrl #(.CNT_W(32), .MEM_TIMEOUT(4), .WAIT_W(8)) dut (
      .clk(clk), .rst(rst), .icode(icode), .instr_valid(instr_valid),
      .imem_ack(imem_ack), .imem_error(imem_error),
      .dmem_ack(dmem_ack), .dmem_error(dmem_error),
      .imem_req(imem_req), .dmem_req(dmem_req), .dmem_wr(dmem_wr),
      .ir_we(ir_we), .cc_we(cc_we), .val_we(val_we), .reg_we(reg_we), .pc_we(pc_we),
      .stat(stat), .state(state), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
   );

   y86_mc_ctrl #(.CNT_W(8), .MEM_TIMEOUT(0), .WAIT_W(8)) dut_b (
      .clk(clk), .rst(rst_b), .icode(4'h1), .instr_valid(1'b1),
      .imem_ack(imem_req_b), .imem_error(1'b0),
      .dmem_ack(dmem_req_b), .dmem_error(1'b0),
      .imem_req(imem_req_b), .dmem_req(dmem_req_b), .dmem_wr(dmem_wr_b),
      .ir_we(ir_we_b), .cc_we(cc_we_b), .val_we(val_we_b), .reg_we(reg_we_b), .pc_we(pc_we_b),
      .stat(stat_b), .state(state_b), .cycle_cnt(cycle_cnt_b), .instr_cnt(instr_cnt_b)
   );

   // Instruction register and memory wait models
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         pc          <= 3'd0;
         icode       <= 4'h0;
         instr_valid <= 1'b1;
         i_wait      <= 0;
         d_wait      <= 0;
      end else begin
         if (ir_we) begin
            icode       <= prog[pc];
            instr_valid <= pvalid[pc];
            pc          <= pc + 3'd1;
         end
         i_wait <= (imem_req && !imem_ack) ? i_wait + 1 : 0;
         d_wait <= (dmem_req && !dmem_ack) ? d_wait + 1 : 0;
      end
   end

   always_comb begin
      imem_ack   = imem_req && (i_wait >= imem_lat);
      imem_error = imem_ack && imem_err_en;
      dmem_ack   = dmem_req && (d_wait >= dmem_lat);
      dmem_error = dmem_ack && dmem_err_en;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic load_prog(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d);
      for (int i = 0; i < 8; i++) begin
         prog[i]   = 4'h0;
         pvalid[i] = 1'b1;
      end
      prog[0] = a; prog[1] = b; prog[2] = c; prog[3] = d;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   // Samples n cycles, one per negedge+1, starting with the current cycle
   task automatic capture(input int n);
      c_imreq = 0; c_irwe = 0; c_ccwe = 0; c_dreq = 0; c_dwr = 0; c_regwe = 0; c_pcwe = 0;
      for (int i = 0; i < n; i++) begin
         tr_state[i] = state;
         tr_ccwe[i]  = cc_we;
         tr_irwe[i]  = ir_we;
         tr_dwr[i]   = dmem_wr;
         c_imreq += int'(imem_req);
         c_irwe  += int'(ir_we);
         c_ccwe  += int'(cc_we);
         c_dreq  += int'(dmem_req);
         c_dwr   += int'(dmem_wr);
         c_regwe += int'(reg_we);
         c_pcwe  += int'(pc_we);
         @(negedge clk);
         #1;
      end
   endtask

   initial begin
      int exp1 [0:18];
      exp1 = '{0,1,2,4,5, 0,1,2,4,5, 0,1,2,3,4,5, 0,1,6};

      #1 rst_b = 1'b1;

      // irmovq, OPq, rmmovq, halt with zero-wait memories
      load_prog(4'h3, 4'h6, 4'h4, 4'h0);
      do_reset();
      chk("rst_state", state, 0);
      chk("rst_stat", stat, 1);
      chk("rst_cycle", cycle_cnt, 0);
      chk("rst_instr", instr_cnt, 0);
      capture(19);
      for (int i = 0; i < 19; i++) chk($sformatf("t1_state[%0d]", i), tr_state[i], exp1[i]);
      chk("t1_ccwe_cnt", c_ccwe, 1);
      chk("t1_ccwe_opq", tr_ccwe[7], 1);
      chk("t1_dwr_rmmov", tr_dwr[13], 1);
      chk("t1_regwe_cnt", c_regwe, 2);
      chk("t1_pcwe_cnt", c_pcwe, 3);
      chk("t1_instr", instr_cnt, 3);
      chk("t1_cycle", cycle_cnt, 19);
      chk("t1_stat", stat, 2);
      capture(3);
      chk("t1_cycle_frozen", cycle_cnt, 19);
      chk("t1_halt_quiet", c_imreq + c_pcwe, 0);

      // nop with instruction memory acking after 3 wait cycles
      load_prog(4'h1, 4'h0, 4'h0, 4'h0);
      imem_lat = 3;
      do_reset();
      capture(7);
      chk("t2_imreq_cnt", c_imreq, 4);
      chk("t2_irwe_cnt", c_irwe, 1);
      chk("t2_irwe_4th", tr_irwe[3], 1);
      chk("t2_state_after", state, 0);
      chk("t2_instr", instr_cnt, 1);
      chk("t2_cycle", cycle_cnt, 7);
      imem_lat = 0;

      // mrmovq with a data memory that never acks
      load_prog(4'h5, 4'h0, 4'h0, 4'h0);
      dmem_lat = 1000;
      do_reset();
      capture(10);
      chk("t3_dreq_cnt", c_dreq, 4);
      chk("t3_dwr_cnt", c_dwr, 0);
      chk("t3_regwe_cnt", c_regwe, 0);
      chk("t3_halt_at7", tr_state[7], 6);
      chk("t3_state", state, 6);
      chk("t3_stat", stat, 3);
      chk("t3_instr", instr_cnt, 0);

      // illegal instruction
      load_prog(4'h1, 4'h0, 4'h0, 4'h0);
      pvalid[0] = 1'b0;
      do_reset();
      capture(3);
      chk("t4_ins_state", state, 6);
      chk("t4_ins_halt_at2", tr_state[2], 6);
      chk("t4_ins_stat", stat, 4);

      // instruction fetch error
      load_prog(4'h1, 4'h0, 4'h0, 4'h0);
      imem_err_en = 1'b1;
      do_reset();
      capture(4);
      chk("t4_adr_irwe_cnt", c_irwe, 0);
      chk("t4_adr_state", state, 6);
      chk("t4_adr_stat", stat, 3);
      imem_err_en = 1'b0;

      // asynchronous reset in the middle of a data write
      load_prog(4'h4, 4'h0, 4'h0, 4'h0);
      do_reset();
      capture(5);
      chk("t5_pre_dreq", dmem_req, 1);
      chk("t5_pre_dwr", dmem_wr, 1);
      rst = 1'b1;
      #1;
      chk("t5_rst_state", state, 0);
      chk("t5_rst_dreq", dmem_req, 0);
      chk("t5_rst_dwr", dmem_wr, 0);
      chk("t5_rst_imreq", imem_req, 0);
      chk("t5_rst_strobes", {ir_we, cc_we, val_we, reg_we, pc_we}, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("t5_rel_state", state, 0);
      chk("t5_rel_imreq", imem_req, 1);
      chk("t5_rel_cycle", cycle_cnt, 0);
      chk("t5_rel_instr", instr_cnt, 0);
      chk("t5_rel_stat", stat, 1);
      capture(4);
      chk("t5_restart_mem", tr_state[3], 3);
      dmem_lat = 0;

      // 8-bit counters on an endless nop loop
      @(negedge clk);
      rst_b = 1'b0;
      #1;
      chk("t6_cycle0", cycle_cnt_b, 0);
      repeat (100) begin @(negedge clk); #1; end
      chk("t6_cycle100", cycle_cnt_b, 100);
      chk("t6_instr100", instr_cnt_b, 25);
      repeat (155) begin @(negedge clk); #1; end
      chk("t6_cycle255", cycle_cnt_b, 255);
      repeat (45) begin @(negedge clk); #1; end
      chk("t6_cycle300_sat", cycle_cnt_b, 255);
      chk("t6_instr300", instr_cnt_b, 75);
      chk("t6_stat", stat_b, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
